// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of N_DIGITS nibble registers onto one shared 7-seg decoder.
// Latency: a store write reaches nib one edge after the store updates; an/frame_tick are registered.
// Backpressure: none; writes are always accepted and the scan free-runs.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   wr_en/addr/data - digit store write port (addresses >= N_DIGITS are dropped)
//   digit_en        - per-digit enable; a 0 keeps that anode dark for its whole slot
//   nib             - registered value of the digit being scanned (to decoder a/b/c/d)
//   an              - active-low anodes, all high during the dead-time gap
//   digit_sel       - index of the current slot
//   frame_tick      - one-cycle pulse on the first BLANK cycle of digit 0 (not the first frame)
// Optional feature: define SEG_SCAN_LZS_EN for leading-zero suppression.
module seg_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                  wr_data,
    input  logic [N_DIGITS-1:0]         digit_en,
    output logic [3:0]                  nib,
    output logic [N_DIGITS-1:0]         an,
    output logic [$clog2(N_DIGITS)-1:0] digit_sel,
    output logic                        frame_tick
);
    localparam int AW = $clog2(N_DIGITS);
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(N_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [AW-1:0]       idx, idx_nxt;
    logic [N_DIGITS-1:0] an_nxt;
    logic                frame_nxt;
    logic [N_DIGITS-1:0] suppress;
    logic [3:0]          store [N_DIGITS];

    // Digit store. The address compare per entry drops out-of-range writes
    // without ever indexing past the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) store[i] <= 4'd0;
        end else if (wr_en) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (wr_addr == AW'(i)) store[i] <= wr_data;
            end
        end
    end

`ifdef SEG_SCAN_LZS_EN
    // A digit above 0 is dark when it and every higher digit hold zero.
    // Uses the live store, so suppression tracks writes cycle by cycle.
    logic above_zero;
    always_comb begin
        above_zero = 1'b1;
        suppress   = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            above_zero  = above_zero && (store[i] == 4'd0);
            suppress[i] = above_zero;
        end
    end
`else
    assign suppress = '0;
`endif

    // Slot sequencing: cnt runs across the whole slot (BLANK then SHOW),
    // so each slot is exactly DIGIT_CYCLES long.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        frame_nxt = 1'b0;
        an_nxt    = '1;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) state_nxt = SHOW;
            end
            SHOW: begin
                if (cnt == DIGIT_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + AW'(1);
                    state_nxt = BLANK;
                    // Wrap into digit 0 marks a new frame; reset itself never pulses.
                    frame_nxt = (idx == IDX_LAST);
                end
            end
            default: state_nxt = BLANK;
        endcase
        // Anodes are computed from next-state values so the registered an
        // lines up with the state it belongs to; digit_en acts at the next edge.
        if (state_nxt == SHOW && digit_en[idx_nxt] && !suppress[idx_nxt])
            an_nxt[idx_nxt] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            nib        <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            // Follows idx one edge later, which lands inside the BLANK gap.
            nib        <= store[idx];
            frame_tick <= frame_nxt;
        end
    end

    assign digit_sel = idx;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl (N=4, 8-cycle slots, 2-cycle blank),
// plus a 3-digit instance for the out-of-range write address.
// Samples 1 time unit after each rising edge; inputs change at the same points.
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, wr_en3;
    logic [1:0] wr_addr, wr_addr3;
    logic [3:0] wr_data, wr_data3;
    logic [3:0] en;
    logic [3:0] nib, nib3;
    logic [3:0] an;
    logic [2:0] an3;
    logic [1:0] digit_sel, sel3;
    logic       frame_tick, ft3;

    int checks = 0;
    int errors = 0;
    int e      = 0;          // edges since reset release
    logic [3:0] mstore [4];
    logic [3:0] m3 [3];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.N_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_en(en), .nib(nib), .an(an), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(.N_DIGITS(3), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .digit_en(3'b111), .nib(nib3), .an(an3), .digit_sel(sel3), .frame_tick(ft3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef SEG_SCAN_LZS_EN
    function automatic logic lit(input int d);
        if (d == 0) return 1'b1;
        for (int j = d; j < 4; j++) if (mstore[j] != 4'd0) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Position model: slot position p, digit d, derived from edge count.
    task automatic check_all();
        int p, d, d3;
        logic [3:0] ea;
        p  = e % 8;
        d  = (e / 8) % 4;
        d3 = (e / 8) % 3;
        ea = 4'hF;
        if (p >= 2 && en[d]) ea[d] = 1'b0;
`ifdef SEG_SCAN_LZS_EN
        if (!lit(d)) ea = 4'hF;
`endif
        chk("an", an, ea);
        chk("digit_sel", digit_sel, d);
        chk("frame_tick", frame_tick, (e > 0 && e % 32 == 0));
        chk("nib", nib, (p == 0) ? mstore[(d + 3) % 4] : mstore[d]);
        if (p < 2) chk("an3_blank", an3, 3'b111);
        chk("digit_sel3", sel3, d3);
        chk("frame_tick3", ft3, (e > 0 && e % 24 == 0));
        chk("nib3", nib3, (p == 0) ? m3[(d3 + 2) % 3] : m3[d3]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_all();
        end
    endtask

    task automatic wait_slot(input int dd, input int pp);
        int n = 0;
        while (!(((e / 8) % 4 == dd) && (e % 8 == pp)) && n < 64) begin
            run(1);
            n++;
        end
        chk("wait_slot", (((e / 8) % 4 == dd) && (e % 8 == pp)), 1);
    endtask

    // The write edge itself is not model-checked; the model updates right after it.
    task automatic wr(input logic [1:0] a, input logic [3:0] dat);
        wr_en = 1'b1; wr_addr = a; wr_data = dat;
        step();
        wr_en = 1'b0;
        mstore[a] = dat;
    endtask

    task automatic wr3(input logic [1:0] a, input logic [3:0] dat);
        wr_en3 = 1'b1; wr_addr3 = a; wr_data3 = dat;
        step();
        wr_en3 = 1'b0;
        if (a < 2'd3) m3[a] = dat;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 4; i++) mstore[i] = 4'd0;
        for (int i = 0; i < 3; i++) m3[i] = 4'd0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; en = 4'b1111;
        clear_models();

        // Reset values, then release between edges.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_nib", nib, 4'h0);
        chk("rst_sel", digit_sel, 2'd0);
        chk("rst_frame", frame_tick, 1'b0);
        rst = 1'b0;
        e = 0;
        check_all();

        // Plain scan over more than one frame (frame_tick at edge 32 only).
        run(40);

        // Store 1,2,3,4 then watch one frame.
        wr(2'd0, 4'h1);
        wr(2'd1, 4'h2);
        wr(2'd2, 4'h3);
        wr(2'd3, 4'h4);
        run(34);

        // Overwrite digit 1 mid-SHOW: nib follows two edges later, an stays lit.
        wait_slot(1, 4);
        wr(2'd1, 4'hA);
        chk("wr_mid_an", an, 4'b1101);
        run(1);
        chk("wr_mid_nib", nib, 4'hA);
        run(4);

        // Disable digit 2 mid-SHOW, keep it off for a full frame, re-enable mid-SHOW.
        wait_slot(2, 4);
        en = 4'b1011;
        run(1);
        chk("en_off_an", an, 4'hF);
        wait_slot(2, 3);
        en = 4'b1111;
        run(1);
        chk("en_on_an", an, 4'b1011);
        run(8);

        // 3-digit instance: address 3 is out of range and must be dropped.
        wr3(2'd3, 4'hF);
        run(26);
        wr3(2'd2, 4'h9);
        run(26);

        // Reset at cnt=5 of digit 3: outputs clear immediately, store clears.
        wait_slot(3, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_nib", nib, 4'h0);
        chk("mid_rst_sel", digit_sel, 2'd0);
        chk("mid_rst_frame", frame_tick, 1'b0);
        clear_models();
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
        check_all();
        run(16);

        // Store {0,0,7,0}: with suppression digits 3,2 are dark; otherwise zeros show.
        wr(2'd1, 4'h7);
        run(34);
        // All zeros: with suppression only digit 0 remains lit.
        wr(2'd1, 4'h0);
        run(34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
